// File: rtl/xgs_athena_rtl_pkg.sv
// Shared scheduler state type and default widths
// for the XGS Athena capture path.
package xgs_athena_rtl_pkg;

    localparam int DEF_ADDR_W      = 64;
    localparam int DEF_PITCH_W     = 16;
    localparam int DEF_LINE_W      = 12;
    localparam int DEF_NUM_BUFFERS = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        REQ,
        XFER,
        DONE
    } sched_state_t;

endpackage

// File: rtl/xgs_line_buf_tracker.sv
// Line-buffer ring bookkeeping: write/read pointers,
// occupancy count, full flag and sticky overflow.
module xgs_line_buf_tracker #(
    parameter  int NUM_BUFFERS = 4,
    localparam int PTR_W       = $clog2(NUM_BUFFERS),
    localparam int CNT_W       = $clog2(NUM_BUFFERS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_active,
    input  logic             line_done,
    input  logic             xfer_done,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] pending,
    output logic             full,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BUFFERS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wr_ptr;
    logic             accept;

    assign full   = (pending == FULL_CNT);
    assign accept = line_done && frame_active && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_ONE;
            if (xfer_done) rd_ptr <= rd_ptr + PTR_ONE;
            // a fill and a drain in the same cycle cancel out
            if (accept && !xfer_done) begin
                pending <= pending + CNT_ONE;
            end else if (!accept && xfer_done) begin
                pending <= pending - CNT_ONE;
            end
            if (line_done && full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/xgs_dma_line_scheduler.sv
// Sequences one host DMA write per completed sensor line
// and flags frame completion.
module xgs_dma_line_scheduler
    import xgs_athena_rtl_pkg::*;
#(
    parameter  int ADDR_W      = DEF_ADDR_W,
    parameter  int PITCH_W     = DEF_PITCH_W,
    parameter  int LINE_W      = DEF_LINE_W,
    parameter  int NUM_BUFFERS = DEF_NUM_BUFFERS,
    localparam int BUF_W       = $clog2(NUM_BUFFERS)
) (
    input  logic              sclk,
    input  logic              srst_n,
    input  logic              cfg_enable,
    input  logic [ADDR_W-1:0] cfg_host_base,
    input  logic [PITCH_W-1:0] cfg_line_pitch,
    input  logic              sof_i,
    input  logic              eof_i,
    input  logic              line_done_i,
    output logic              buf_full_o,
    output logic              dma_req_o,
    output logic [ADDR_W-1:0] dma_addr_o,
    output logic [BUF_W-1:0]  dma_buf_o,
    input  logic              dma_ack_i,
    input  logic              dma_done_i,
    output logic              frame_done_o,
    output logic [LINE_W-1:0] line_count_o,
    output logic              overflow_o,
    output logic              sof_err_o
);

    localparam int                CNT_W    = $clog2(NUM_BUFFERS + 1);
    localparam logic [LINE_W-1:0] LINE_MAX = '1;
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [ADDR_W-1:0]  cur_addr;
    logic [PITCH_W-1:0] pitch_q;
    logic [LINE_W-1:0]  line_idx;
    logic               eof_seen;
    logic [CNT_W-1:0]   pending;
    logic               frame_active;
    logic               sof_accept;
    logic               xfer_done;

    assign frame_active = (state_q != IDLE);
    assign sof_accept   = (state_q == IDLE) && sof_i && cfg_enable;
    assign xfer_done    = (state_q == XFER) && dma_done_i;
    assign dma_addr_o   = cur_addr;
    assign line_count_o = line_idx;

    xgs_line_buf_tracker #(
        .NUM_BUFFERS (NUM_BUFFERS)
    ) u_tracker (
        .clk          (sclk),
        .rst_n        (srst_n),
        .frame_active (frame_active),
        .line_done    (line_done_i),
        .xfer_done    (xfer_done),
        .rd_ptr       (dma_buf_o),
        .pending      (pending),
        .full         (buf_full_o),
        .overflow     (overflow_o)
    );

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // frame base lives in cur_addr; it only moves after a finished line
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            cur_addr  <= '0;
            pitch_q   <= '0;
            line_idx  <= '0;
            eof_seen  <= 1'b0;
            sof_err_o <= 1'b0;
        end else begin
            if (sof_accept) begin
                cur_addr <= cfg_host_base;
                pitch_q  <= cfg_line_pitch;
                line_idx <= '0;
                eof_seen <= 1'b0;
            end else if (frame_active) begin
                if (eof_i) eof_seen <= 1'b1;
                if (sof_i) sof_err_o <= 1'b1;
            end
            if (xfer_done) begin
                cur_addr <= cur_addr + ADDR_W'(pitch_q);
                if (line_idx != LINE_MAX) line_idx <= line_idx + LINE_ONE;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dma_req_o    = 1'b0;
        frame_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sof_accept) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (pending != '0) begin
                    state_d = REQ;
                end else if (eof_seen) begin
                    state_d = DONE;
                end
            end
            REQ: begin
                dma_req_o = 1'b1;
                if (dma_ack_i) state_d = XFER;
            end
            XFER: begin
                if (dma_done_i) state_d = ACTIVE;
            end
            DONE: begin
                frame_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
